maze_walker_dp: RTL and testbench

Parametrised successor to the rat-in-maze location datapath. Holds the mouse's current (X,Y) cell and computes the neighbour for a requested direction, with edge detection on both grid bounds. Records the walked path on a bounded LIFO that supports backtracking. On `finish`, replays the recorded path bottom-to-top over a valid/ready stream. Sits between the maze controller FSM and the maze-memory / result-output logic.

---
 rtl/maze_pkg.sv | 21 ++
 rtl/maze_path_stack.sv | 52 +++++
 rtl/maze_walker_dp.sv | 186 ++++++++++++++++++
 tb/tb_maze_walker_dp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze walker datapath: direction codes, FSM states,
// and the packed-location width helper.
package maze_pkg;

  localparam logic [1:0] DIR_Y_DEC = 2'b00;
  localparam logic [1:0] DIR_X_INC = 2'b01;
  localparam logic [1:0] DIR_X_DEC = 2'b10;
  localparam logic [1:0] DIR_Y_INC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  // A location packs {X,Y}, so it is twice the coordinate width.
  function automatic int unsigned loc_w(input int unsigned coord_w);
    return 2 * coord_w;
  endfunction

endpackage

// File: rtl/maze_path_stack.sv
// Bounded LIFO of walked cells with push/pop at the top and a separate
// indexed read port used to replay the path bottom-to-top.
module maze_path_stack #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic [CNT_W-1:0] rd_addr,
  output logic [WIDTH-1:0] top_data_c,
  output logic [WIDTH-1:0] rd_data_c,
  output logic [CNT_W-1:0] count,
  output logic             empty_c,
  output logic             full_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full_c && !clr;
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)                  count_d = '0;
    else if (do_push)         count_d = count_q + CNT_W'(1);
    else if (pop && !empty_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  // Storage carries no reset: slots above count are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[AW'(count_q)] <= push_data;
  end

  assign top_data_c = mem_q[AW'(count_q - CNT_W'(1))];
  assign rd_data_c  = (rd_addr < CNT_W'(DEPTH)) ? mem_q[AW'(rd_addr)] : '0;

endmodule

// File: rtl/maze_walker_dp.sv
// Mouse location datapath: current cell, neighbour/edge logic, path stack
// with backtracking, and a valid/ready replay of the walked path.
module maze_walker_dp
  import maze_pkg::*;
#(
  parameter  int unsigned COORD_W = 4,
  parameter  int unsigned DEPTH   = 64,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
  localparam int unsigned LOC_W   = loc_w(COORD_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOC_W-1:0] start_loc,
  input  logic [1:0]       dir,
  input  logic             step,
  input  logic             back,
  input  logic             finish,
  output logic [LOC_W-1:0] cur_loc,
  output logic [LOC_W-1:0] nxt_loc,
  output logic             edge_c,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             path_valid,
  input  logic             path_ready,
  output logic [LOC_W-1:0] path_loc,
  output logic             path_last,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [LOC_W-1:0]   cur_q, cur_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0]   idx_q, idx_d, idx_nxt;
  logic               pv_q, pv_d, plast_q, plast_d, busy_q, busy_d;
  logic [LOC_W-1:0]   pl_q, pl_d;

  logic               st_clr, st_push, st_pop;
  logic [CNT_W-1:0]   rd_addr, st_count;
  logic [LOC_W-1:0]   top_data, rd_data;
  logic               st_empty, st_full;

  logic [COORD_W-1:0] cur_x, cur_y, nx, ny;
  logic               at_edge;

  maze_path_stack #(.DEPTH(DEPTH), .WIDTH(LOC_W)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr        (st_clr),
    .push       (st_push),
    .pop        (st_pop),
    .push_data  (cur_q),
    .rd_addr    (rd_addr),
    .top_data_c (top_data),
    .rd_data_c  (rd_data),
    .count      (st_count),
    .empty_c    (st_empty),
    .full_c     (st_full)
  );

  assign cur_x = cur_q[LOC_W-1:COORD_W];
  assign cur_y = cur_q[COORD_W-1:0];

  // Neighbour in dir; an edge move leaves the location unchanged.
  always_comb begin
    at_edge = 1'b0;
    nx      = cur_x;
    ny      = cur_y;
    unique case (dir)
      DIR_Y_DEC: begin at_edge = (cur_y == '0); ny = cur_y - COORD_W'(1); end
      DIR_X_INC: begin at_edge = (cur_x == '1); nx = cur_x + COORD_W'(1); end
      DIR_X_DEC: begin at_edge = (cur_x == '0); nx = cur_x - COORD_W'(1); end
      default:   begin at_edge = (cur_y == '1); ny = cur_y + COORD_W'(1); end
    endcase
  end

  assign edge_c  = at_edge;
  assign nxt_loc = at_edge ? cur_q : {nx, ny};
  assign idx_nxt = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    idx_d   = idx_q;
    pv_d    = pv_q;
    pl_d    = pl_q;
    plast_d = plast_q;
    st_clr  = 1'b0;
    st_push = 1'b0;
    st_pop  = 1'b0;
    rd_addr = '0;
    if (start) begin
      state_d = ST_WALK;
      cur_d   = start_loc;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      idx_d   = '0;
      pv_d    = 1'b0;
      plast_d = 1'b0;
      st_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ST_WALK: begin
          if (finish) begin
            // Preload the first beat so path_valid rises the next cycle.
            state_d = ST_REPLAY;
            idx_d   = '0;
            pv_d    = 1'b1;
            pl_d    = st_empty ? cur_q : rd_data;
            plast_d = st_empty;
          end else if (back) begin
            if (st_empty) unf_d = 1'b1;
            else begin
              st_pop = 1'b1;
              cur_d  = top_data;
            end
          end else if (step && !at_edge) begin
            if (st_full) ovf_d = 1'b1;
            else begin
              st_push = 1'b1;
              cur_d   = {nx, ny};
            end
          end
        end
        ST_REPLAY: begin
          if (pv_q && path_ready) begin
            if (plast_q) begin
              state_d = ST_IDLE;
              pv_d    = 1'b0;
              plast_d = 1'b0;
              st_clr  = 1'b1;
            end else begin
              rd_addr = idx_nxt;
              idx_d   = idx_nxt;
              pl_d    = (idx_nxt == st_count) ? cur_q : rd_data;
              plast_d = (idx_nxt == st_count);
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      idx_q   <= '0;
      pv_q    <= 1'b0;
      pl_q    <= '0;
      plast_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      idx_q   <= idx_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      plast_q <= plast_d;
      busy_q  <= busy_d;
    end
  end

  assign cur_loc    = cur_q;
  assign count      = st_count;
  assign empty      = st_empty;
  assign full       = st_full;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign path_valid = pv_q;
  assign path_loc   = pl_q;
  assign path_last  = plast_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_maze_walker_dp.sv
// Bench for maze_walker_dp: directed scenarios plus random walks, checked
// against a queue-based model of the mouse position and its recorded path.
module tb_maze_walker_dp;

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 2 * CW;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int          GMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, step, back, finish, path_ready;
  logic [LW-1:0]    start_loc;
  logic [1:0]       dir;
  logic [LW-1:0]    cur_loc, nxt_loc, path_loc;
  logic             edge_c, empty, full, ovf, unf, path_valid, path_last, busy;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  maze_walker_dp #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_loc(start_loc), .dir(dir),
    .step(step), .back(back), .finish(finish), .cur_loc(cur_loc),
    .nxt_loc(nxt_loc), .edge_c(edge_c), .empty(empty), .full(full),
    .count(count), .ovf(ovf), .unf(unf), .path_valid(path_valid),
    .path_ready(path_ready), .path_loc(path_loc), .path_last(path_last),
    .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: coordinates as integers, path as a queue of cells.
  int            mx, my, mstate;  // mstate: 0 idle, 1 walk, 2 replay
  logic [LW-1:0] mstk[$];
  bit            movf, munf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LW-1:0] pack(input int x, input int y);
    return {CW'(x), CW'(y)};
  endfunction

  function automatic bit neighbour(input int x, input int y, input logic [1:0] d,
                                   output int nx, output int ny);
    nx = x;
    ny = y;
    case (d)
      2'd0:    ny = y - 1;
      2'd1:    nx = x + 1;
      2'd2:    nx = x - 1;
      default: ny = y + 1;
    endcase
    return (nx < 0 || nx > GMAX || ny < 0 || ny > GMAX);
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mstate = 0; movf = 0; munf = 0;
    mstk.delete();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_cur"},   32'(cur_loc),    32'(pack(mx, my)));
    check({tag, "_count"}, 32'(count),      32'(mstk.size()));
    check({tag, "_ovf"},   32'(ovf),        32'(movf));
    check({tag, "_unf"},   32'(unf),        32'(munf));
    check({tag, "_busy"},  32'(busy),       32'(mstate != 0));
    check({tag, "_empty"}, 32'(empty),      32'(mstk.size() == 0));
    check({tag, "_full"},  32'(full),       32'(mstk.size() == DEPTH));
    check({tag, "_pv"},    32'(path_valid), 32'(mstate == 2));
  endtask

  // One command cycle; entered and left at posedge+1.
  task automatic do_cmd(input bit st, input logic [LW-1:0] sl, input logic [1:0] d,
                        input bit sp, input bit bk, input bit fn);
    int nx, ny;
    bit e;
    logic [LW-1:0] t;
    start = st; start_loc = sl; dir = d; step = sp; back = bk; finish = fn;
    #2;
    e = neighbour(mx, my, d, nx, ny);
    check("edge", 32'(edge_c), 32'(e));
    check("nxt",  32'(nxt_loc), 32'(e ? pack(mx, my) : pack(nx, ny)));
    @(posedge clk); #1;
    start = 0; step = 0; back = 0; finish = 0;
    if (st) begin
      mx = int'(sl[LW-1:CW]); my = int'(sl[CW-1:0]);
      mstk.delete(); movf = 0; munf = 0; mstate = 1;
    end else if (mstate == 1) begin
      if (fn) mstate = 2;
      else if (bk) begin
        if (mstk.size() == 0) munf = 1;
        else begin
          t = mstk.pop_back();
          mx = int'(t[LW-1:CW]); my = int'(t[CW-1:0]);
        end
      end else if (sp && !e) begin
        if (mstk.size() == DEPTH) movf = 1;
        else begin
          mstk.push_back(pack(mx, my));
          mx = nx; my = ny;
        end
      end
    end
    check_regs("cmd");
  endtask

  // Drain a replay; mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic replay(input int mode);
    logic [LW-1:0] exp[$];
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int cyc = 0;
    bit r;
    exp = mstk;
    exp.push_back(pack(mx, my));
    while (k < exp.size() && cyc < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      path_ready = r;
      #2;
      check("rp_valid", 32'(path_valid), 32'd1);
      check("rp_loc",   32'(path_loc),   32'(exp[k]));
      check("rp_last",  32'(path_last),  32'(k == exp.size() - 1));
      if (r) k++;
      @(posedge clk); #1;
      cyc++;
    end
    path_ready = 1'b0;
    if (k < exp.size()) check("rp_timeout", 32'(k), 32'(exp.size()));
    if (mode == 0) check("rp_cycles", 32'(cyc), 32'(exp.size()));
    mstk.delete();
    mstate = 0;
    check_regs("rp_end");
  endtask

  initial begin
    rst = 1'b0; start = 0; step = 0; back = 0; finish = 0; path_ready = 0;
    start_loc = '0; dir = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset_ploc", 32'(path_loc), 32'd0);
    check("reset_plast", 32'(path_last), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic walk and full-throughput replay.
    do_cmd(1, pack(2, 3), 2'd0, 0, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    check("t1_cur", 32'(cur_loc), 32'h44);
    check("t1_count", 32'(count), 32'd3);
    do_cmd(0, '0, 2'd0, 0, 0, 1);
    replay(0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);

    // Grid edges: no move, no flag.
    do_cmd(1, pack(0, 5), 2'd2, 0, 0, 0);
    do_cmd(0, '0, 2'd2, 1, 0, 0);
    do_cmd(1, pack(GMAX, 7), 2'd1, 0, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    do_cmd(1, pack(9, GMAX), 2'd3, 1, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    do_cmd(1, pack(9, 0), 2'd0, 0, 0, 0);
    do_cmd(0, '0, 2'd0, 1, 0, 0);

    // Overflow and underflow.
    do_cmd(1, pack(5, 5), 2'd1, 0, 0, 0);
    repeat (5) do_cmd(0, '0, 2'd1, 1, 0, 0);
    check("t3_ovf", 32'(ovf), 32'd1);
    repeat (5) do_cmd(0, '0, 2'd1, 0, 1, 0);
    check("t3_back_home", 32'(cur_loc), 32'h55);
    check("t3_unf", 32'(unf), 32'd1);

    // Stalled replay.
    do_cmd(1, pack(1, 1), 2'd0, 0, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    do_cmd(0, '0, 2'd0, 0, 0, 1);
    replay(1);

    // Command priority.
    do_cmd(1, pack(8, 8), 2'd0, 0, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd3, 1, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 1, 0);
    do_cmd(0, '0, 2'd2, 1, 0, 0);
    do_cmd(0, '0, 2'd0, 0, 1, 1);
    replay(0);

    // Start aborts a replay, then async reset mid-walk.
    do_cmd(1, pack(3, 3), 2'd1, 0, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd1, 1, 0, 0);
    do_cmd(0, '0, 2'd1, 0, 0, 1);
    @(posedge clk); #1;
    check("t6_held", 32'(path_loc), 32'(pack(3, 3)));
    do_cmd(1, pack(6, 6), 2'd0, 0, 0, 0);
    do_cmd(0, '0, 2'd0, 1, 0, 0);
    do_cmd(0, '0, 2'd2, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    check("async_ploc", 32'(path_loc), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Random walks with random replay back-pressure.
    for (int it = 0; it < 20; it++) begin
      do_cmd(1, LW'($urandom), 2'd0, 0, 0, 0);
      for (int c = 0; c < 25; c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        do_cmd(0, '0, 2'($urandom), r < 7, r >= 6, 0);
      end
      do_cmd(0, '0, 2'd0, 0, 0, 1);
      replay(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
